// File: rtl/rlc_game_system_datain_pio_if.sv
// Avalon-MM slave bus bundle for the datain PIO: CPU-side master drives, PIO-side slave responds.
interface rlc_game_system_datain_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/rlc_game_system_datain_pio.sv
// Input PIO: synchronized in_port, per-bit edge capture, maskable irq; read latency 1, no backpressure.
// Optional macro DATAIN_PIO_BIT_CLEAR_EN: EDGECAP writes are write-1-to-clear instead of clear-all.
module rlc_game_system_datain_pio #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [WIDTH-1:0]              in_port,
  rlc_game_system_datain_pio_if.slave   bus
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  prev;
  logic [WIDTH-1:0]                  irqmask;
  logic [WIDTH-1:0]                  edgecap;
  logic [31:0]                       readdata_q;
  logic [SYNC_STAGES:0]              prime_sr;
  logic                              primed;

  logic                              rd;
  logic                              wr;
  logic [WIDTH-1:0]                  edge_sel;
  logic [WIDTH-1:0]                  capture;
  logic [WIDTH-1:0]                  clr;
  logic [31:0]                       rd_mux;
  logic                              unused_wd;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign primed = prime_sr[SYNC_STAGES];
  assign rd     = bus.chipselect && !bus.read_n;
  assign wr     = bus.chipselect && !bus.write_n;

  // Edge detection only becomes meaningful once both sync and prev hold real pin
  // samples; until the chain has refilled after reset, the cleared flops would
  // fake a rising edge for any pin held high through reset.
  always_comb begin
    edge_sel = sync ^ prev;
    if (EDGE_TYPE == 0) edge_sel = sync & ~prev;
    else if (EDGE_TYPE == 1) edge_sel = ~sync & prev;
    capture = primed ? edge_sel : '0;
  end

  always_comb begin
    clr = '0;
    if (wr && bus.address == 2'd3) begin
`ifdef DATAIN_PIO_BIT_CLEAR_EN
      clr = bus.writedata[WIDTH-1:0];
`else
      clr = '1;
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = sync;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev       <= '0;
      irqmask    <= '0;
      edgecap    <= '0;
      readdata_q <= '0;
      prime_sr   <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev     <= sync;
      prime_sr <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
      // Capture is OR-ed in after the clear so a same-cycle edge survives.
      edgecap  <= (edgecap & ~clr) | capture;
      if (wr && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      if (rd) readdata_q <= rd_mux;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edgecap & irqmask);
  assign unused_wd    = ^bus.writedata;

endmodule
